// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the instruction-memory word address
// and buffers {pc, instr} pairs in a 2-entry queue presented to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              misalign_err
);

    logic [31:0] pc;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        head;
    logic [1:0]  count;
    logic        tail;
    logic        pop;
    logic        push;

    assign imem_addr = pc[ADDR_W+1:2];
    assign out_valid = (count != 2'd0);
    assign out_instr = q_instr[head];
    assign out_pc    = q_pc[head];

    // Tail slot is head+count mod 2; when full it aliases the head slot, which is
    // safe only because a push at full implies the head is popped that same edge.
    assign tail = head ^ count[0];
    assign pop  = out_valid & out_ready;
    assign push = !redirect_valid & ((count != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            count        <= '0;
            head         <= 1'b0;
            misalign_err <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= '0;
            if (redirect_pc[1:0] != 2'b00)
                misalign_err <= 1'b1;
        end else begin
            if (push) begin
                q_pc[tail]    <= pc;
                q_instr[tail] <= imem_instr;
                pc            <= pc + 32'd4;
            end
            if (pop)
                head <= ~head;
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
        end
    end

endmodule
